// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared constants for the gamepad front end and grid_controller.
//   - Button bit indices inside the 12-bit pad vector (bit 0 is shifted first).
//   - BTN_* codes consumed by grid_controller on controller_in (index + 1).
//   - Serial frame length and the poll-reader FSM state encoding.
//   - encode_buttons(): priority encoder, lowest pressed index wins.
// ---------------------------------------------------------------------------
package tetris_pkg;

  // A pad frame carries 16 serial bits. Only the low 12 map to buttons.
  localparam int FRAME_BITS  = 16;
  localparam int NUM_BUTTONS = 12;

  // Bit position of each button in the raw vector, in pad shift order.
  localparam int IDX_B      = 0;
  localparam int IDX_Y      = 1;
  localparam int IDX_SELECT = 2;
  localparam int IDX_START  = 3;
  localparam int IDX_UP     = 4;
  localparam int IDX_DOWN   = 5;
  localparam int IDX_LEFT   = 6;
  localparam int IDX_RIGHT  = 7;
  localparam int IDX_A      = 8;
  localparam int IDX_X      = 9;
  localparam int IDX_L      = 10;
  localparam int IDX_R      = 11;

  // Codes presented to grid_controller. Each code is the button index plus
  // one, so zero is free to mean "nothing pressed".
  localparam logic [3:0] BTN_NONE   = 4'd0;
  localparam logic [3:0] BTN_B      = 4'd1;
  localparam logic [3:0] BTN_Y      = 4'd2;
  localparam logic [3:0] BTN_SELECT = 4'd3;
  localparam logic [3:0] BTN_START  = 4'd4;
  localparam logic [3:0] BTN_UP     = 4'd5;
  localparam logic [3:0] BTN_DOWN   = 4'd6;
  localparam logic [3:0] BTN_LEFT   = 4'd7;
  localparam logic [3:0] BTN_RIGHT  = 4'd8;
  localparam logic [3:0] BTN_A      = 4'd9;
  localparam logic [3:0] BTN_X      = 4'd10;
  localparam logic [3:0] BTN_L      = 4'd11;
  localparam logic [3:0] BTN_R      = 4'd12;

  // Serial reader FSM states, in the order a poll walks through them.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_GAP   = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_DONE  = 3'd5
  } reader_state_t;

  // Priority encoder: scanning from the top index down means the last hit,
  // i.e. the lowest pressed index, sets the final code. That gives
  // B over START over LEFT over RIGHT when several are held together.
  function automatic logic [3:0] encode_buttons(input logic [NUM_BUTTONS-1:0] raw);
    logic [3:0] code;
    code = BTN_NONE;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (raw[i]) begin
        code = 4'(i + 1);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/snes_input_controller_reader.sv
// ---------------------------------------------------------------------------
// snes_serial_reader
// Runs one serial read of an SNES-style pad each time i_start is seen in
// S_IDLE: a latch pulse, a gap, then 16 low/high pad clock pulses. It samples
// the synchronized data line once per bit and delivers the 12 button bits.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset (aborts a poll)
//   i_start        in   poll request; honoured only while idle
//   i_pad_data     in   raw pad data line, active low, asynchronous to clk
//   o_pad_latch    out  parallel-load strobe to the pad, active high
//   o_pad_clk      out  shift clock to the pad, idles high
//   o_raw          out  captured buttons, active high (1 = pressed)
//   o_frame_valid  out  one-cycle pulse (S_DONE) when o_raw holds a new frame
// ---------------------------------------------------------------------------
module snes_serial_reader
  import tetris_pkg::*;
#(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_pad_data,
  output logic        o_pad_latch,
  output logic        o_pad_clk,
  output logic [11:0] o_raw,
  output logic        o_frame_valid
);

  localparam logic [9:0] LATCH_LAST = 10'(LATCH_CYCLES - 1);
  localparam logic [9:0] HALF_LAST  = 10'(HALF_CYCLES - 1);
  localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS);
  localparam logic [4:0] KEEP_BITS  = 5'(NUM_BUTTONS);

  reader_state_t r_state;
  reader_state_t w_nextState;

  logic        r_sync1;
  logic        r_sync2;
  logic [9:0]  r_timer;
  logic [4:0]  r_bitCount;
  logic [11:0] r_shift;

  logic w_timerLast;
  logic w_sample;
  logic w_padLatch;
  logic w_padClk;
  logic w_frameValid;

  // The pad line is asynchronous, so it crosses through two flops before the
  // FSM looks at it. Both reset to 1, the level of a released button.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pad_data;
      r_sync2 <= r_sync1;
    end
  end

  // State register for the poll sequence. Reset returns it to idle at once,
  // dropping whatever poll was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and pad-pin decode. Every timed state lasts until the shared
  // timer hits its last count. The sample strobe fires on the final cycle of
  // the gap (bit 0) and of each high phase while bits remain. The 16th high
  // phase finishes the last clock pulse without sampling.
  always_comb begin
    w_nextState  = r_state;
    w_timerLast  = 1'b0;
    w_sample     = 1'b0;
    w_padLatch   = 1'b0;
    w_padClk     = 1'b1;
    w_frameValid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = S_LATCH;
        end
      end
      S_LATCH: begin
        w_padLatch  = 1'b1;
        w_timerLast = (r_timer == LATCH_LAST);
        if (w_timerLast) begin
          w_nextState = S_GAP;
        end
      end
      S_GAP: begin
        w_timerLast = (r_timer == HALF_LAST);
        if (w_timerLast) begin
          w_sample    = 1'b1;
          w_nextState = S_LOW;
        end
      end
      S_LOW: begin
        w_padClk    = 1'b0;
        w_timerLast = (r_timer == HALF_LAST);
        if (w_timerLast) begin
          w_nextState = S_HIGH;
        end
      end
      S_HIGH: begin
        w_timerLast = (r_timer == HALF_LAST);
        if (w_timerLast) begin
          if (r_bitCount < LAST_BIT) begin
            w_sample    = 1'b1;
            w_nextState = S_LOW;
          end else begin
            w_nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_frameValid = 1'b1;
        w_nextState  = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Phase timer, bit counter and capture register. The timer restarts at
  // every phase boundary and is held at zero while idle, so each timed state
  // starts counting from 0. The capture register keeps the line level as
  // seen (1 = released) so its all-ones reset reads as no buttons; bits
  // 12..15 are clocked out of the pad but not stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer    <= 10'd0;
      r_bitCount <= 5'd0;
      r_shift    <= '1;
    end else begin
      if (w_timerLast || (r_state == S_IDLE)) begin
        r_timer <= 10'd0;
      end else begin
        r_timer <= r_timer + 10'd1;
      end

      if (r_state == S_IDLE) begin
        r_bitCount <= 5'd0;
      end else if (w_sample) begin
        r_bitCount <= r_bitCount + 5'd1;
        if (r_bitCount < KEEP_BITS) begin
          r_shift[r_bitCount[3:0]] <= r_sync2;
        end
      end
    end
  end

  // The pad drives 0 for pressed, so the buttons come out inverted.
  assign o_raw         = ~r_shift;
  assign o_pad_latch   = w_padLatch;
  assign o_pad_clk     = w_padClk;
  assign o_frame_valid = w_frameValid;

endmodule

// File: rtl/snes_input_controller.sv
// ---------------------------------------------------------------------------
// snes_input_controller
// Polls an SNES-style gamepad at roughly 60 Hz, debounces the 12 buttons
// across consecutive polls and encodes them into the 4-bit code that
// grid_controller reads on controller_in.
//
// Ports
//   clk             in   50 MHz system clock
//   reset           in   synchronous, active-high reset
//   pad_data        in   serial data from the pad, active low, asynchronous
//   pad_latch       out  parallel-load strobe to the pad, active high
//   pad_clk         out  shift clock to the pad, idles high
//   controller_out  out  encoded button code (0 = none, index + 1 otherwise)
//   buttons         out  debounced button vector, active high
//   poll_done       out  one-cycle pulse when a poll's 16 bits are captured
// ---------------------------------------------------------------------------
module snes_input_controller
  import tetris_pkg::*;
#(
  parameter int LATCH_CYCLES   = 600,
  parameter int HALF_CYCLES    = 300,
  parameter int POLL_CYCLES    = 833333,
  parameter int DEBOUNCE_POLLS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [3:0]  controller_out,
  output logic [11:0] buttons,
  output logic        poll_done
);

  localparam logic [19:0] POLL_LAST = 20'(POLL_CYCLES - 1);
  localparam logic [3:0]  DB_TARGET = 4'(DEBOUNCE_POLLS);

  logic [19:0] r_pollCnt;
  logic [11:0] r_prevRaw;
  logic [3:0]  r_dbCount;
  logic [11:0] r_buttons;
  logic [3:0]  r_code;

  logic        w_pollWrap;
  logic [11:0] w_raw;
  logic        w_frameValid;
  logic        w_rawMatch;
  logic [3:0]  w_dbCountNext;

  // Free-running poll interval counter. The wrap cycle is the poll request,
  // so the first poll starts a full interval after reset releases. A wrap
  // that arrives while a poll is still running is simply ignored by the
  // reader.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pollCnt <= 20'd0;
    end else if (w_pollWrap) begin
      r_pollCnt <= 20'd0;
    end else begin
      r_pollCnt <= r_pollCnt + 20'd1;
    end
  end

  assign w_pollWrap = (r_pollCnt == POLL_LAST);

  snes_serial_reader #(
    .LATCH_CYCLES (LATCH_CYCLES),
    .HALF_CYCLES  (HALF_CYCLES)
  ) u_reader (
    .clk           (clk),
    .reset         (reset),
    .i_start       (w_pollWrap),
    .i_pad_data    (pad_data),
    .o_pad_latch   (pad_latch),
    .o_pad_clk     (pad_clk),
    .o_raw         (w_raw),
    .o_frame_valid (w_frameValid)
  );

  // Agreement count for the debouncer. A frame matching the previous one
  // extends the run, saturating at the target. A different frame starts a
  // new run of one, which is what lets a target of 1 update immediately.
  always_comb begin
    w_rawMatch    = (w_raw == r_prevRaw);
    w_dbCountNext = 4'd1;
    if (w_rawMatch) begin
      if (r_dbCount >= DB_TARGET) begin
        w_dbCountNext = DB_TARGET;
      end else begin
        w_dbCountNext = r_dbCount + 4'd1;
      end
    end
  end

  // Debounce and encode, evaluated only on the frame-valid cycle. The
  // outputs move only once a run of identical frames reaches the target and
  // otherwise hold, so a held button keeps a steady code and a one-poll
  // glitch never reaches grid_controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prevRaw <= 12'd0;
      r_dbCount <= 4'd0;
      r_buttons <= 12'd0;
      r_code    <= BTN_NONE;
    end else if (w_frameValid) begin
      r_dbCount <= w_dbCountNext;
      if (!w_rawMatch) begin
        r_prevRaw <= w_raw;
      end
      if (w_dbCountNext == DB_TARGET) begin
        r_buttons <= w_raw;
        r_code    <= encode_buttons(w_raw);
      end
    end
  end

  assign controller_out = r_code;
  assign buttons        = r_buttons;
  assign poll_done      = w_frameValid;

endmodule

// File: tb/tb_snes_input_controller.sv
// ---------------------------------------------------------------------------
// tb_snes_input_controller
// Directed bench for snes_input_controller with short timing parameters.
// A behavioural pad model answers the latch/clock interface.
// ---------------------------------------------------------------------------
module tb_snes_input_controller;

  localparam int LATCH_CYCLES   = 4;
  localparam int HALF_CYCLES    = 2;
  localparam int POLL_CYCLES    = 120;
  localparam int DEBOUNCE_POLLS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [3:0]  controller_out;
  logic [11:0] buttons;
  logic        poll_done;

  int checks = 0;
  int errors = 0;

  logic [11:0] padPressed = 12'h000;
  logic [15:0] padShift   = 16'hFFFF;

  snes_input_controller #(
    .LATCH_CYCLES   (LATCH_CYCLES),
    .HALF_CYCLES    (HALF_CYCLES),
    .POLL_CYCLES    (POLL_CYCLES),
    .DEBOUNCE_POLLS (DEBOUNCE_POLLS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pad_data       (pad_data),
    .pad_latch      (pad_latch),
    .pad_clk        (pad_clk),
    .controller_out (controller_out),
    .buttons        (buttons),
    .poll_done      (poll_done)
  );

  always #5 clk = ~clk;

  // Pad model: the latch loads the frame (0 = pressed, bits 12..15 read 1).
  // The next bit is presented on the falling pad clock edge, so each bit is
  // steady long before the controller samples it at the end of the high
  // phase, even with these very short phases and the synchronizer delay.
  always @(posedge pad_latch) begin
    padShift = {4'hF, ~padPressed};
  end

  always @(negedge pad_clk) begin
    if (pad_latch === 1'b0) begin
      padShift = {1'b1, padShift[15:1]};
    end
  end

  assign pad_data = padShift[0];

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Selects which buttons the pad model reports from the next latch onward.
  task automatic applyStimulus(input logic [11:0] pressed);
    padPressed = pressed;
  endtask

  // Waits for the next poll_done, then steps one more cycle so the
  // registered outputs of that poll are visible.
  task automatic waitPoll();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (poll_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL poll_timeout: poll_done seen=%0d required=1", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pad_latch, pad_clk, controller_out, buttons, poll_done} !== {1'b0, 1'b1, 4'd0, 12'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: latch=%b clk=%b code=%0d buttons=%h done=%b required latch=0 clk=1 code=0 buttons=000 done=0",
               pad_latch, pad_clk, controller_out, buttons, poll_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_poll();
    int cyc;
    int latchHigh;
    int lows;
    int badWidth;
    int curRun;
    int doneCycles;
    int nonZero;
    applyStimulus(12'h000);
    cyc = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (pad_latch === 1'b1) begin
        cyc = n;
        break;
      end
    end
    checks++;
    if (cyc != POLL_CYCLES) begin
      errors++;
      $display("[TB] FAIL first_latch_cycle: got %0d required %0d", cyc, POLL_CYCLES);
    end
    latchHigh  = 1;
    lows       = 0;
    badWidth   = 0;
    curRun     = 0;
    doneCycles = 0;
    nonZero    = 0;
    for (int n = 0; n < 110; n++) begin
      @(posedge clk);
      #1;
      if (pad_latch === 1'b1) latchHigh++;
      if (pad_clk === 1'b0) begin
        curRun++;
      end else if (curRun > 0) begin
        lows++;
        if (curRun != HALF_CYCLES) badWidth++;
        curRun = 0;
      end
      if (poll_done === 1'b1) doneCycles++;
      if (controller_out !== 4'd0) nonZero++;
    end
    checks++;
    if (latchHigh != LATCH_CYCLES) begin
      errors++;
      $display("[TB] FAIL latch_width: got %0d required %0d", latchHigh, LATCH_CYCLES);
    end
    checks++;
    if (lows != 16) begin
      errors++;
      $display("[TB] FAIL low_pulse_count: got %0d required 16", lows);
    end
    checks++;
    if (badWidth != 0) begin
      errors++;
      $display("[TB] FAIL low_pulse_width: %0d pulses not %0d cycles wide, required 0", badWidth, HALF_CYCLES);
    end
    checks++;
    if (doneCycles != 1) begin
      errors++;
      $display("[TB] FAIL poll_done_pulses: got %0d required 1", doneCycles);
    end
    checks++;
    if (nonZero != 0) begin
      errors++;
      $display("[TB] FAIL idle_code: nonzero in %0d cycles required 0", nonZero);
    end
  endtask

  task automatic test_right_debounce();
    applyStimulus(12'h080);
    waitPoll();
    checks++;
    if ({controller_out, buttons} !== {4'd0, 12'h000}) begin
      errors++;
      $display("[TB] FAIL right_first_poll: code=%0d buttons=%h required code=0 buttons=000", controller_out, buttons);
    end
    waitPoll();
    checks++;
    if ({controller_out, buttons} !== {4'd8, 12'h080}) begin
      errors++;
      $display("[TB] FAIL right_second_poll: code=%0d buttons=%h required code=8 buttons=080", controller_out, buttons);
    end
  endtask

  task automatic test_combo();
    applyStimulus(12'h048);
    waitPoll();
    checks++;
    if (controller_out !== 4'd8) begin
      errors++;
      $display("[TB] FAIL combo_hold_prev: code=%0d required 8", controller_out);
    end
    waitPoll();
    checks++;
    if ({controller_out, buttons} !== {4'd4, 12'h048}) begin
      errors++;
      $display("[TB] FAIL combo_priority: code=%0d buttons=%h required code=4 buttons=048", controller_out, buttons);
    end
    applyStimulus(12'h000);
    waitPoll();
    checks++;
    if (controller_out !== 4'd4) begin
      errors++;
      $display("[TB] FAIL combo_release_1: code=%0d required 4", controller_out);
    end
    waitPoll();
    checks++;
    if ({controller_out, buttons} !== {4'd0, 12'h000}) begin
      errors++;
      $display("[TB] FAIL combo_release_2: code=%0d buttons=%h required code=0 buttons=000", controller_out, buttons);
    end
  endtask

  task automatic test_glitch();
    applyStimulus(12'h040);
    waitPoll();
    checks++;
    if (controller_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL glitch_poll_1: code=%0d required 0", controller_out);
    end
    applyStimulus(12'h000);
    for (int p = 2; p <= 3; p++) begin
      waitPoll();
      checks++;
      if (controller_out !== 4'd0) begin
        errors++;
        $display("[TB] FAIL glitch_poll_%0d: code=%0d required 0", p, controller_out);
      end
    end
  endtask

  task automatic test_hold_release();
    logic [3:0] expCode;
    applyStimulus(12'h080);
    for (int p = 1; p <= 5; p++) begin
      waitPoll();
      expCode = (p == 1) ? 4'd0 : 4'd8;
      checks++;
      if (controller_out !== expCode) begin
        errors++;
        $display("[TB] FAIL hold_poll_%0d: code=%0d required %0d", p, controller_out, expCode);
      end
    end
    applyStimulus(12'h000);
    waitPoll();
    checks++;
    if (controller_out !== 4'd8) begin
      errors++;
      $display("[TB] FAIL hold_release_1: code=%0d required 8", controller_out);
    end
    waitPoll();
    checks++;
    if (controller_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL hold_release_2: code=%0d required 0", controller_out);
    end
  endtask

  task automatic test_reset_mid_poll();
    int lows;
    int cyc;
    logic prevClk;
    bit reached;
    applyStimulus(12'h080);
    waitPoll();
    waitPoll();
    checks++;
    if (controller_out !== 4'd8) begin
      errors++;
      $display("[TB] FAIL midreset_precondition: code=%0d required 8", controller_out);
    end
    lows    = 0;
    reached = 1'b0;
    prevClk = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (prevClk === 1'b1 && pad_clk === 1'b0) lows++;
      prevClk = pad_clk;
      if (lows == 9) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("[TB] FAIL midreset_reach_bit9: low pulses seen %0d required 9", lows);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({pad_latch, pad_clk, controller_out, buttons, poll_done} !== {1'b0, 1'b1, 4'd0, 12'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_clear: latch=%b clk=%b code=%0d buttons=%h done=%b required latch=0 clk=1 code=0 buttons=000 done=0",
               pad_latch, pad_clk, controller_out, buttons, poll_done);
    end
    reset = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (pad_latch === 1'b1) begin
        cyc = n;
        break;
      end
    end
    checks++;
    if (cyc != POLL_CYCLES) begin
      errors++;
      $display("[TB] FAIL midreset_restart_cycle: got %0d required %0d", cyc, POLL_CYCLES);
    end
    waitPoll();
    checks++;
    if (controller_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midreset_debounce_restart: code=%0d required 0", controller_out);
    end
    waitPoll();
    checks++;
    if ({controller_out, buttons} !== {4'd8, 12'h080}) begin
      errors++;
      $display("[TB] FAIL midreset_recover: code=%0d buttons=%h required code=8 buttons=080", controller_out, buttons);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_idle_poll();
    test_right_debounce();
    test_combo();
    test_glitch();
    test_hold_release();
    test_reset_mid_poll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
